nx_ram_indirect_access_mt: RTL
==============================

# nx_ram_indirect_access_mt

Multi-table single-port RAM with a built-in indirect-access command engine. Software reaches any of N_TABLES tables through command/status/data registers; hardware reaches them through a direct port with strict priority. A bounded yield/timeout mechanism prevents software starvation. An automatic init runs after reset, and init-with-increment is optional. It sits beside the register block of any engine needing several software-visible tables behind one arbitrated port.

## Interface
- N_DATA_BITS, 32, entry width
- N_ENTRIES, 16, entries per table (≥2)
- N_TABLES, 2, number of tables (≥1)
- N_TIMER_BITS, 6, starvation timer width
- RESET_DATA, 0, N_DATA_BITS fill value for init
- Widths: AW = max(1, clog2(N_ENTRIES)); TW = max(1, clog2(N_TABLES))

Ports:
- clk  in  1  clock; the only clock
- rst  in  1  reset, synchronous, active-high
- cmnd_stb  in  1  command register write strobe
- cmnd_op  in  4  opcode: 0 NOP, 1 READ, 2 WRITE, 3 INIT, 4 INIT_INC, others illegal
- cmnd_table_id  in  TW  target table
- cmnd_addr  in  AW  target entry
- stat_code  out  3  0 READY, 1 BUSY, 2 TIMEOUT, 3 BAD_OP, 4 BAD_ADDR
- stat_datawords  out  5  constant ceil(N_DATA_BITS/32)
- stat_addr  out  AW  entry of last performed software access
- stat_table_id  out  TW  table of last performed software access
- wr_stb  in  1  data register load strobe
- wr_dat  in  N_DATA_BITS  data register load value
- rd_dat  out  N_DATA_BITS  data register contents
- hw_cs  in  1  hardware access request
- hw_we  in  1  hardware write
- hw_table_id  in  TW  hardware table
- hw_add  in  AW  hardware entry
- hw_bwe  in  N_DATA_BITS  per-bit write enable
- hw_din  in  N_DATA_BITS  hardware write data
- hw_dout  out  N_DATA_BITS  hardware read data, registered
- hw_yield  out  1  request that hardware drop hw_cs

## Operation
- States: RST_INIT, IDLE, PEND (waiting for a grant), CMD_INIT.
- Reset values: stat_code = 1, stat_addr = 0, stat_table_id = 0, rd_dat = RESET_DATA, hw_dout = RESET_DATA, hw_yield = 1.
- RST_INIT: writes RESET_DATA to every entry of every table. Order is table-major, entry ascending, one write per cycle. While in RST_INIT, hw_cs is ignored: writes are dropped and hw_dout holds RESET_DATA.
- Grant: a software access is performed in a cycle with hw_cs = 0. Hardware always wins a contended cycle.
- cmnd_stb in IDLE, any stat_code except BUSY:
  - illegal op → BAD_OP;
  - READ/WRITE with addr ≥ N_ENTRIES, or any op with table ≥ N_TABLES → BAD_ADDR;
  - otherwise BUSY and enter PEND.
- cmnd_stb while BUSY is ignored.
- READ: data register ← mem[table][addr].
- WRITE: mem[table][addr] ← data register, full width.
- NOP: READY with no memory access.
- INIT: fills the selected table with RESET_DATA, one entry per granted cycle.
- INIT_INC: fills entry i of the selected table with (data register + i) mod 2^N_DATA_BITS.
- wr_stb loads the data register in any state; a READ completing in the same cycle wins.
- Hardware write: mem ← (hw_din & hw_bwe) | (mem & ~hw_bwe). Hardware read: hw_dout is valid in the next cycle.
- hw_add ≥ N_ENTRIES or hw_table_id ≥ N_TABLES: write dropped; read returns 0.
- Starvation timer:
  - increments each cycle a pending software access is blocked; clears on each granted access;
  - at 2^N_TIMER_BITS−1, hw_yield asserts in the next cycle and holds until the next grant;
  - after a further 2^N_TIMER_BITS blocked cycles, the command aborts with TIMEOUT. For INIT/INIT_INC, entries already written are kept and the rest are untouched.
- rst at any time aborts the current operation and restarts RST_INIT.

## Timing
- Reset init runs from the first cycle after rst falls and takes N_TABLES·N_ENTRIES cycles. stat_code = 0 and hw_yield = 0 in the following cycle.
- Uncontended READ, cmnd_stb at cycle T:
  - T+1: BUSY, access performed;
  - T+2: rd_dat valid, READY, stat_addr/stat_table_id updated.
- WRITE follows the same timing, with memory updated at the end of T+1.
- NOP/BAD_OP/BAD_ADDR: status is final at T+1.
- INIT/INIT_INC, uncontended: BUSY T+1..T+N_ENTRIES, READY at T+N_ENTRIES+1. stat_addr tracks the entry written.
- Hardware read data appears exactly 1 cycle after hw_cs & !hw_we.

## Configuration
- NX_RAM_IA_INIT_INC_EN defined: INIT_INC behaves as specified, and an incrementer/adder path is compiled in.
- Not defined: opcode 4 returns BAD_OP; no adder is synthesised.

## Test plan
- Reset init: N_TABLES=2, N_ENTRIES=16, RESET_DATA=0xA5 → stat_code=1 for 32 cycles, then 0. Backdoor every entry = 0xA5.
- Uncontended WRITE/READ: wr_dat=0x1234_5678, WRITE t1 a5, then wr_dat=0, READ t1 a5 → rd_dat=0x12345678 at T+2. Table 0 entry 5 unchanged.
- Bad commands: op 7 → stat 3. READ addr 16 with N_ENTRIES=16 → stat 4. Table 2 with N_TABLES=2 → stat 4. No memory change.
- Starvation: N_TIMER_BITS=3, hw_cs held high, READ issued → hw_yield rises after 7 blocked cycles. Releasing hw_cs one cycle later completes the READ. Never releasing it → TIMEOUT after a further 8 cycles.
- Hardware port: write hw_din=0xFFFF_FFFF, hw_bwe=0x0000_FF00 to 0x11 → read back 0x0000_FF11; hw_dout 1 cycle after the read.
- INIT_INC with macro: data=0xFFFF_FFFE, table 0 → entries 0..3 = 0xFFFFFFFE, 0xFFFFFFFF, 0, 1. Without macro → stat 3. rst asserted mid-INIT → full reset init restarts.

Source files
------------

// File: rtl/nx_ram_indirect_access_mt_if.sv
// Bus bundle for nx_ram_indirect_access_mt: software command/status/data registers
// plus the direct hardware table port.
interface nx_ram_indirect_access_mt_if #(
  parameter int N_DATA_BITS = 32,
  parameter int N_ENTRIES   = 16,
  parameter int N_TABLES    = 2
);
  localparam int AW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int TW = (N_TABLES > 1) ? $clog2(N_TABLES) : 1;

  logic                   cmnd_stb;
  logic [3:0]             cmnd_op;
  logic [TW-1:0]          cmnd_table_id;
  logic [AW-1:0]          cmnd_addr;
  logic [2:0]             stat_code;
  logic [4:0]             stat_datawords;
  logic [AW-1:0]          stat_addr;
  logic [TW-1:0]          stat_table_id;
  logic                   wr_stb;
  logic [N_DATA_BITS-1:0] wr_dat;
  logic [N_DATA_BITS-1:0] rd_dat;
  logic                   hw_cs;
  logic                   hw_we;
  logic [TW-1:0]          hw_table_id;
  logic [AW-1:0]          hw_add;
  logic [N_DATA_BITS-1:0] hw_bwe;
  logic [N_DATA_BITS-1:0] hw_din;
  logic [N_DATA_BITS-1:0] hw_dout;
  logic                   hw_yield;

  modport master (
    output cmnd_stb, cmnd_op, cmnd_table_id, cmnd_addr, wr_stb, wr_dat,
           hw_cs, hw_we, hw_table_id, hw_add, hw_bwe, hw_din,
    input  stat_code, stat_datawords, stat_addr, stat_table_id, rd_dat,
           hw_dout, hw_yield
  );

  modport slave (
    input  cmnd_stb, cmnd_op, cmnd_table_id, cmnd_addr, wr_stb, wr_dat,
           hw_cs, hw_we, hw_table_id, hw_add, hw_bwe, hw_din,
    output stat_code, stat_datawords, stat_addr, stat_table_id, rd_dat,
           hw_dout, hw_yield
  );
endinterface

// File: rtl/nx_ram_indirect_access_mt.sv
// Multi-table single-port RAM with an indirect-access command engine, hardware-priority
// arbitration and a yield/timeout starvation guard. NX_RAM_IA_INIT_INC_EN enables INIT_INC.
module nx_ram_indirect_access_mt #(
  parameter int                     N_DATA_BITS  = 32,
  parameter int                     N_ENTRIES    = 16,
  parameter int                     N_TABLES     = 2,
  parameter int                     N_TIMER_BITS = 6,
  parameter logic [N_DATA_BITS-1:0] RESET_DATA   = '0
) (
  input logic                      clk,
  input logic                      rst,
  nx_ram_indirect_access_mt_if.slave bus
);
  localparam int AW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int TW = (N_TABLES > 1) ? $clog2(N_TABLES) : 1;
  localparam int NE = N_TABLES * N_ENTRIES;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;
  localparam int CW = $clog2(NE + 1);

  localparam logic [CW-1:0]           LAST_FLAT = CW'(NE - 1);
  localparam logic [CW-1:0]           LAST_ENT  = CW'(N_ENTRIES - 1);
  localparam logic [N_TIMER_BITS-1:0] TMR_MAX   = '1;
  localparam logic [N_TIMER_BITS-1:0] TMR_PRE   = TMR_MAX - N_TIMER_BITS'(1);
  localparam logic [4:0]              DATAWORDS = 5'((N_DATA_BITS + 31) / 32);

  localparam logic [1:0] ST_RST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_PEND     = 2'd2;
  localparam logic [1:0] ST_CMD_INIT = 2'd3;

  localparam logic [3:0] OP_NOP      = 4'd0;
  localparam logic [3:0] OP_READ     = 4'd1;
  localparam logic [3:0] OP_WRITE    = 4'd2;
  localparam logic [3:0] OP_INIT     = 4'd3;
  localparam logic [3:0] OP_INIT_INC = 4'd4;

  localparam logic [2:0] SC_READY    = 3'd0;
  localparam logic [2:0] SC_BUSY     = 3'd1;
  localparam logic [2:0] SC_TIMEOUT  = 3'd2;
  localparam logic [2:0] SC_BAD_OP   = 3'd3;
  localparam logic [2:0] SC_BAD_ADDR = 3'd4;

  function automatic logic [IW-1:0] flat_idx(input logic [TW-1:0] t, input logic [AW-1:0] a);
    return IW'(int'(t) * N_ENTRIES + int'(a));
  endfunction

  logic [N_DATA_BITS-1:0]  mem_q [NE];
  logic [1:0]              state_q, state_d;
  logic [2:0]              stat_code_q, stat_code_d;
  logic [AW-1:0]           stat_addr_q, stat_addr_d;
  logic [TW-1:0]           stat_tbl_q, stat_tbl_d;
  logic [N_DATA_BITS-1:0]  data_q, data_d;
  logic [N_DATA_BITS-1:0]  hw_dout_q, hw_dout_d;
  logic                    yield_q, yield_d;
  logic [N_TIMER_BITS-1:0] timer_q, timer_d;
  logic [3:0]              op_q, op_d;
  logic [TW-1:0]           tbl_q, tbl_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic                    hw_grab_s, hw_valid_s, blocked_s, op_legal_s;
  logic [AW-1:0]           sw_entry_s;
  logic [IW-1:0]           port_idx_s;
  logic                    port_we_s;
  logic [N_DATA_BITS-1:0]  port_wdata_s, mem_rdata_s, init_val_s;

  assign hw_grab_s  = bus.hw_cs && (state_q != ST_RST_INIT);
  assign hw_valid_s = (32'(bus.hw_table_id) < N_TABLES) && (32'(bus.hw_add) < N_ENTRIES);
  assign blocked_s  = bus.hw_cs && ((state_q == ST_PEND) || (state_q == ST_CMD_INIT));
  assign sw_entry_s = (state_q == ST_CMD_INIT) ? cnt_q[AW-1:0] : addr_q;

`ifdef NX_RAM_IA_INIT_INC_EN
  assign op_legal_s = (bus.cmnd_op <= OP_INIT_INC);
  assign init_val_s = (op_q == OP_INIT_INC) ? (data_q + N_DATA_BITS'(cnt_q)) : RESET_DATA;
`else
  assign op_legal_s = (bus.cmnd_op <= OP_INIT);
  assign init_val_s = RESET_DATA;
`endif

  // Single port address: reset init sweep, then hardware, then the software engine.
  always_comb begin
    if (state_q == ST_RST_INIT) begin
      port_idx_s = cnt_q[IW-1:0];
    end else if (bus.hw_cs) begin
      port_idx_s = hw_valid_s ? flat_idx(bus.hw_table_id, bus.hw_add) : '0;
    end else begin
      port_idx_s = flat_idx(tbl_q, sw_entry_s);
    end
  end

  assign mem_rdata_s = mem_q[port_idx_s];

  // Next-state logic for the command engine, hardware port and starvation guard.
  always_comb begin
    state_d      = state_q;
    stat_code_d  = stat_code_q;
    stat_addr_d  = stat_addr_q;
    stat_tbl_d   = stat_tbl_q;
    data_d       = bus.wr_stb ? bus.wr_dat : data_q;
    hw_dout_d    = hw_dout_q;
    yield_d      = yield_q;
    timer_d      = timer_q;
    op_d         = op_q;
    tbl_d        = tbl_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    port_we_s    = 1'b0;
    port_wdata_s = RESET_DATA;

    if (hw_grab_s) begin
      if (bus.hw_we) begin
        port_we_s    = hw_valid_s;
        port_wdata_s = (bus.hw_din & bus.hw_bwe) | (mem_rdata_s & ~bus.hw_bwe);
      end else begin
        hw_dout_d = hw_valid_s ? mem_rdata_s : '0;
      end
    end else begin
      hw_dout_d = hw_dout_q;
    end

    case (state_q)
      ST_RST_INIT: begin
        port_we_s    = 1'b1;
        port_wdata_s = RESET_DATA;
        hw_dout_d    = RESET_DATA;
        if (cnt_q == LAST_FLAT) begin
          state_d     = ST_IDLE;
          stat_code_d = SC_READY;
          yield_d     = 1'b0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_IDLE: begin
        if (bus.cmnd_stb && (stat_code_q != SC_BUSY)) begin
          if (!op_legal_s) begin
            stat_code_d = SC_BAD_OP;
          end else if (32'(bus.cmnd_table_id) >= N_TABLES) begin
            stat_code_d = SC_BAD_ADDR;
          end else if (((bus.cmnd_op == OP_READ) || (bus.cmnd_op == OP_WRITE)) &&
                       (32'(bus.cmnd_addr) >= N_ENTRIES)) begin
            stat_code_d = SC_BAD_ADDR;
          end else if (bus.cmnd_op == OP_NOP) begin
            stat_code_d = SC_READY;
          end else begin
            stat_code_d = SC_BUSY;
            op_d        = bus.cmnd_op;
            tbl_d       = bus.cmnd_table_id;
            addr_d      = bus.cmnd_addr;
            cnt_d       = '0;
            timer_d     = '0;
            state_d     = ((bus.cmnd_op == OP_READ) || (bus.cmnd_op == OP_WRITE)) ?
                          ST_PEND : ST_CMD_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (!bus.hw_cs) begin
          state_d     = ST_IDLE;
          stat_code_d = SC_READY;
          stat_addr_d = addr_q;
          stat_tbl_d  = tbl_q;
          timer_d     = '0;
          yield_d     = 1'b0;
          if (op_q == OP_READ) begin
            data_d = mem_rdata_s;
          end else begin
            port_we_s    = 1'b1;
            port_wdata_s = data_q;
          end
        end else begin
          state_d = ST_PEND;
        end
      end
      ST_CMD_INIT: begin
        if (!bus.hw_cs) begin
          port_we_s    = 1'b1;
          port_wdata_s = init_val_s;
          stat_addr_d  = cnt_q[AW-1:0];
          stat_tbl_d   = tbl_q;
          timer_d      = '0;
          yield_d      = 1'b0;
          if (cnt_q == LAST_ENT) begin
            state_d     = ST_IDLE;
            stat_code_d = SC_READY;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = ST_CMD_INIT;
        end
      end
      default: begin
        state_d = ST_RST_INIT;
      end
    endcase

    // Two phases: count to the yield point, then a full timer span before giving up.
    if (blocked_s) begin
      if (!yield_q) begin
        if (timer_q == TMR_PRE) begin
          timer_d = '0;
          yield_d = 1'b1;
        end else begin
          timer_d = timer_q + N_TIMER_BITS'(1);
        end
      end else if (timer_q == TMR_MAX) begin
        state_d     = ST_IDLE;
        stat_code_d = SC_TIMEOUT;
        yield_d     = 1'b0;
        timer_d     = '0;
        cnt_d       = '0;
      end else begin
        timer_d = timer_q + N_TIMER_BITS'(1);
      end
    end else begin
      timer_d = timer_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RST_INIT;
      stat_code_q <= SC_BUSY;
      stat_addr_q <= '0;
      stat_tbl_q  <= '0;
      data_q      <= RESET_DATA;
      hw_dout_q   <= RESET_DATA;
      yield_q     <= 1'b1;
      timer_q     <= '0;
      op_q        <= OP_NOP;
      tbl_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      stat_code_q <= stat_code_d;
      stat_addr_q <= stat_addr_d;
      stat_tbl_q  <= stat_tbl_d;
      data_q      <= data_d;
      hw_dout_q   <= hw_dout_d;
      yield_q     <= yield_d;
      timer_q     <= timer_d;
      op_q        <= op_d;
      tbl_q       <= tbl_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Table storage; reset only restarts the init sweep, contents are not cleared here.
  always_ff @(posedge clk) begin
    if (port_we_s && !rst) begin
      mem_q[port_idx_s] <= port_wdata_s;
    end
  end

  assign bus.stat_code      = stat_code_q;
  assign bus.stat_datawords = DATAWORDS;
  assign bus.stat_addr      = stat_addr_q;
  assign bus.stat_table_id  = stat_tbl_q;
  assign bus.rd_dat         = data_q;
  assign bus.hw_dout        = hw_dout_q;
  assign bus.hw_yield       = yield_q;
endmodule
